// File: rtl/par_pkg.sv
// Shared types and constants for the frame parity checker.
package par_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/par_frame_chk_if.sv
// Beat stream in, frame result and error count out.
interface par_frame_chk_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);

  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              last;
  logic              par_in;
  logic              mode;
  logic              clr_cnt;
  logic              res_valid;
  logic              parity_ok;
  logic              len_err;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output data_in, valid, last, par_in, mode, clr_cnt,
    input  res_valid, parity_ok, len_err, err_count
  );

  modport slave (
    input  data_in, valid, last, par_in, mode, clr_cnt,
    output res_valid, parity_ok, len_err, err_count
  );

endinterface

// File: rtl/par_reduce.sv
// XOR-reduce of one data beat.
module par_reduce #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              par_o
);

  assign par_o = ^data_i;

endmodule

// File: rtl/par_frame_chk.sv
// Accumulates parity over a multi-beat frame and reports the parity/length
// result one cycle after the last beat, with a saturating failure counter.
module par_frame_chk
  import par_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  par_frame_chk_if.slave     bus
);

  localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_e            state_q, state_d;
  logic              acc_q, acc_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              mode_q, mode_d;
  logic              res_valid_q, res_valid_d;
  logic              parity_ok_q, parity_ok_d;
  logic              len_err_q, len_err_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic beat_par_c;
  logic frame_par_c;
  logic frame_mode_c;
  logic frame_len_c;

  par_reduce #(.DATA_W(DATA_W)) u_reduce (
    .data_i (bus.data_in),
    .par_o  (beat_par_c)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    beats_d      = beats_q;
    mode_d       = mode_q;
    res_valid_d  = 1'b0;
    parity_ok_d  = 1'b0;
    len_err_d    = 1'b0;
    err_count_d  = err_count_q;
    frame_par_c  = 1'b0;
    frame_mode_c = mode_q;
    frame_len_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          if (bus.last) begin
            // Single-beat frame: evaluated with the mode presented on this beat.
            res_valid_d  = 1'b1;
            frame_par_c  = beat_par_c ^ bus.par_in;
            frame_mode_c = bus.mode;
          end else begin
            state_d = ACC;
            acc_d   = beat_par_c;
            mode_d  = bus.mode;
            beats_d = BEAT_W'(1);
          end
        end
      end
      ACC: begin
        if (bus.valid) begin
          if (bus.last) begin
            res_valid_d = 1'b1;
            frame_par_c = acc_q ^ beat_par_c ^ bus.par_in;
            // beats_q excludes this last beat, so >= MAX means total > MAX.
            frame_len_c = (beats_q >= BEAT_MAX);
            state_d     = IDLE;
            acc_d       = 1'b0;
            beats_d     = '0;
          end else begin
            acc_d = acc_q ^ beat_par_c;
            if (beats_q < BEAT_MAX) begin
              beats_d = beats_q + BEAT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    len_err_d   = res_valid_d & frame_len_c;
    parity_ok_d = res_valid_d & ~frame_len_c &
                  ((frame_mode_c == MODE_ODD) ? frame_par_c : ~frame_par_c);

    // Clear wins over a failure landing in the same cycle.
    if (bus.clr_cnt) begin
      err_count_d = '0;
    end else if (res_valid_d && !parity_ok_d && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      beats_q     <= '0;
      mode_q      <= MODE_EVEN;
      res_valid_q <= 1'b0;
      parity_ok_q <= 1'b0;
      len_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      mode_q      <= mode_d;
      res_valid_q <= res_valid_d;
      parity_ok_q <= parity_ok_d;
      len_err_q   <= len_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.parity_ok = parity_ok_q;
  assign bus.len_err   = len_err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_par_frame_chk.sv
// Directed and random frames checked cycle-by-cycle against a frame-level model.
module tb_par_frame_chk;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned CNT_SAT   = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  par_frame_chk_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  par_frame_chk #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: beats of the open frame and the mode taken at its start.
  logic [DATA_W-1:0] frame_q[$];
  bit                in_frame  = 0;
  bit                frame_mode = 0;
  int unsigned       exp_cnt   = 0;
  bit                exp_rv    = 0;
  bit                exp_ok    = 0;
  bit                exp_len   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit frame_total_parity(input bit par);
    int ones = 0;
    foreach (frame_q[i])
      for (int b = 0; b < int'(DATA_W); b++)
        if (frame_q[i][b]) ones++;
    if (par) ones++;
    return bit'(ones % 2);
  endfunction

  task automatic model_step(input bit r, input bit v, input bit l,
                            input logic [DATA_W-1:0] d, input bit p,
                            input bit m, input bit c);
    bit fail;
    exp_rv  = 0;
    exp_ok  = 0;
    exp_len = 0;
    if (r) begin
      in_frame = 0;
      frame_q.delete();
      exp_cnt = 0;
    end else begin
      if (v) begin
        if (!in_frame) begin
          frame_mode = m;
          frame_q.delete();
          in_frame = 1;
        end
        frame_q.push_back(d);
        if (l) begin
          exp_rv   = 1;
          exp_len  = (frame_q.size() > MAX_BEATS);
          exp_ok   = !exp_len && (frame_total_parity(p) == frame_mode);
          in_frame = 0;
        end
      end
      fail = exp_rv && !exp_ok;
      if (c) exp_cnt = 0;
      else if (fail && exp_cnt < CNT_SAT) exp_cnt++;
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit l,
                     input logic [DATA_W-1:0] d, input bit p,
                     input bit m, input bit c);
    rst         = r;
    bus.valid   = v;
    bus.last    = l;
    bus.data_in = d;
    bus.par_in  = p;
    bus.mode    = m;
    bus.clr_cnt = c;
    @(posedge clk);
    #1;
    model_step(r, v, l, d, p, m, c);
    check_eq("res_valid", 32'(bus.res_valid), 32'(exp_rv));
    check_eq("parity_ok", 32'(bus.parity_ok), 32'(exp_ok));
    check_eq("len_err",   32'(bus.len_err),   32'(exp_len));
    check_eq("err_count", 32'(bus.err_count), 32'(exp_cnt));
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.valid = 0; bus.last = 0; bus.data_in = '0;
    bus.par_in = 0; bus.mode = 0; bus.clr_cnt = 0;

    cyc(1, 0, 0, '0, 0, 0, 0);
    cyc(1, 1, 1, 8'hff, 1, 1, 1);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_err_count", 32'(bus.err_count), 32'd0);
    idle();

    // Even single beat 0x03, par 0: passes.
    cyc(0, 1, 1, 8'h03, 0, 0, 0);
    check_eq("single_even_ok", 32'(bus.parity_ok), 32'd1);
    check_eq("single_even_cnt", 32'(bus.err_count), 32'd0);
    idle();

    // Odd 3-beat frame: par 1 fails, par 0 passes.
    cyc(0, 1, 0, 8'h01, 0, 1, 0);
    cyc(0, 1, 0, 8'h00, 0, 1, 0);
    cyc(0, 1, 1, 8'h00, 1, 1, 0);
    check_eq("odd3_fail_ok", 32'(bus.parity_ok), 32'd0);
    check_eq("odd3_fail_cnt", 32'(bus.err_count), 32'd1);
    cyc(0, 1, 0, 8'h01, 0, 1, 0);
    cyc(0, 1, 0, 8'h00, 0, 1, 0);
    cyc(0, 1, 1, 8'h00, 0, 1, 0);
    check_eq("odd3_pass_ok", 32'(bus.parity_ok), 32'd1);
    idle();

    // Oversize 5-beat frame, then a 2-beat frame.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00, 0, 0, 0);
    cyc(0, 1, 1, 8'h00, 0, 0, 0);
    check_eq("long_len_err", 32'(bus.len_err), 32'd1);
    check_eq("long_ok", 32'(bus.parity_ok), 32'd0);
    check_eq("long_cnt", 32'(bus.err_count), 32'd2);
    cyc(0, 1, 0, 8'h00, 0, 0, 0);
    cyc(0, 1, 1, 8'h00, 0, 0, 0);
    check_eq("short_len_err", 32'(bus.len_err), 32'd0);
    check_eq("short_ok", 32'(bus.parity_ok), 32'd1);

    // Back-to-back single-beat frames, no gaps.
    cyc(0, 1, 1, 8'h01, 1, 0, 0);
    check_eq("b2b0_ok", 32'(bus.parity_ok), 32'd1);
    cyc(0, 1, 1, 8'h01, 0, 0, 0);
    check_eq("b2b1_ok", 32'(bus.parity_ok), 32'd0);
    cyc(0, 1, 1, 8'h00, 0, 1, 0);
    check_eq("b2b2_ok", 32'(bus.parity_ok), 32'd0);
    check_eq("sat_cnt", 32'(bus.err_count), 32'd3);
    idle();

    // Clear coinciding with a failing frame, then saturate again.
    cyc(0, 1, 1, 8'h01, 0, 0, 1);
    check_eq("clr_vs_fail", 32'(bus.err_count), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 8'h01, 0, 0, 0);
    check_eq("sat5_cnt", 32'(bus.err_count), 32'd3);
    cyc(0, 0, 0, '0, 0, 0, 1);

    // Mode toggled mid-frame is ignored.
    cyc(0, 1, 0, 8'h01, 0, 0, 0);
    cyc(0, 1, 0, 8'h00, 0, 1, 0);
    cyc(0, 1, 1, 8'h00, 1, 1, 0);
    check_eq("mode_mid_ok", 32'(bus.parity_ok), 32'd1);

    // Reset mid-frame discards it; only the new frame reports.
    cyc(0, 1, 0, 8'h07, 0, 1, 0);
    cyc(0, 1, 0, 8'h03, 0, 1, 0);
    cyc(1, 0, 0, '0, 0, 0, 0);
    check_eq("rst_mid_rv", 32'(bus.res_valid), 32'd0);
    cyc(0, 1, 1, 8'h01, 1, 0, 0);
    check_eq("after_rst_rv", 32'(bus.res_valid), 32'd1);
    check_eq("after_rst_ok", 32'(bus.parity_ok), 32'd1);
    idle();
    check_eq("after_rst_once", 32'(bus.res_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) < 3),
          DATA_W'($urandom),
          1'($urandom),
          1'($urandom),
          ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
